alu_ctrl: RTL
=============

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data and accumulator width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  command valid.
REQ-005 SHALL have port in_ready  output  1  command accepted when in_valid and in_ready are both high at a rising edge.
REQ-006 SHALL have port in_op  input  3  opcode, encoded as in REQ-013.
REQ-007 SHALL have port in_data  input  WIDTH  signed operand.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  result consumed when out_valid and out_ready are both high at a rising edge.
REQ-010 SHALL have port out_data  output  WIDTH  signed result, equal to the accumulator.
REQ-011 SHALL have ports out_zero and out_negative  output  1 each  registered flags of out_data.
REQ-012 SHALL have port err  output  1  sticky reserved-opcode flag.

Function
REQ-013 Opcodes SHALL be: 000 LOAD (acc<=in_data); 001 ADD (acc+in_data); 010 SUB (acc-in_data); 011 MUL (acc*in_data); 100 HALF (acc/2, in_data ignored); 101 CLR (acc<=0); 110/111 reserved.
REQ-014 A reserved opcode SHALL leave acc unchanged, produce a normal result beat carrying acc, and set err.
REQ-015 Arithmetic SHALL be signed two's complement and truncated to WIDTH bits (wrap); MUL keeps the low WIDTH bits of the product.
REQ-016 HALF SHALL round toward zero (-7 -> -3, 7 -> 3).
REQ-017 ADD/SUB/MUL/HALF SHALL use the alu sub-module with bus_a=acc, bus_b=latched operand, alu_sel=opcode; LOAD, CLR and reserved opcodes SHALL bypass the ALU.
REQ-018 FSM SHALL have states IDLE, EXEC and HOLD.
REQ-019 IDLE: in_ready=1 and out_valid=0; on accept, latch in_op/in_data and go to EXEC.
REQ-020 EXEC (one cycle): in_ready=0; at its closing edge, write the result into acc, register out_zero/out_negative from the new acc, and go to HOLD.
REQ-021 HOLD: out_valid=1 and out_data, flags and acc held stable; if out_ready=0, stay.
REQ-022 HOLD with out_ready=1: in_ready=1; on simultaneous accept, go to EXEC, otherwise go to IDLE.
REQ-023 Latency SHALL be: command accepted at edge k, out_valid high from edge k+2; back-to-back throughput is one command per 2 cycles.
REQ-024 in_ready SHALL depend combinationally only on state and out_ready; in_valid SHALL not affect it.
REQ-025 acc SHALL change only at the closing edge of EXEC.
REQ-026 err SHALL clear only on reset.

Reset
REQ-027 rst high at a rising edge SHALL force: state IDLE; acc, out_data, latched op and operand all 0; out_valid 0; out_zero 1; out_negative 0; err 0.
REQ-028 Reset in EXEC or HOLD SHALL discard the pending command or result with no beat emitted.
REQ-029 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-030 Shared package alu_pkg SHALL hold W_ALU_SEL=3, the opcode enum (OP_LOAD..OP_CLR) and the FSM state enum.
REQ-031 alu_ctrl SHALL instantiate exactly one existing alu sub-module (WIDTH passed through); all registers live in alu_ctrl.

Verification
REQ-032 Reset then idle, WIDTH=8: out_valid=0, out_data=0, out_zero=1, in_ready=1.
REQ-033 LOAD 5, ADD 3, SUB 10, MUL -3, with out_ready=1 -> beats 5, 8, -2 (negative=1), 6; each beat 2 cycles after its accept.
REQ-034 LOAD 127, ADD 1 -> -128 (wrap, negative=1); LOAD 16, MUL 16 -> 0 (zero=1).
REQ-035 LOAD -7, HALF -> -3; CLR -> 0 (zero=1); op 110 -> acc unchanged beat, err=1, stays 1 after a later LOAD.
REQ-036 out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0 and out_data stable; on release, next command accepted in the same cycle.
REQ-037 rst asserted in EXEC after LOAD 9 -> no beat emitted, acc=0, following ADD 1 yields 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU: opcode encoding, ALU select width
// and the controller FSM states.
package alu_pkg;

  localparam int W_ALU_SEL = 3;

  typedef enum logic [W_ALU_SEL-1:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_MUL  = 3'b011,
    OP_HALF = 3'b100,
    OP_CLR  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_HOLD
  } state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational signed ALU: ADD/SUB/MUL/HALF on bus_a and bus_b,
// results wrapped to WIDTH bits.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0]     bus_a,
  input  logic signed [WIDTH-1:0]     bus_b,
  input  logic        [W_ALU_SEL-1:0] alu_sel,
  output logic signed [WIDTH-1:0]     result
);

  logic signed [WIDTH-1:0] w_biased;

  // Adding the sign bit before the arithmetic shift makes HALF round toward zero.
  assign w_biased = bus_a + $signed({{(WIDTH-1){1'b0}}, bus_a[WIDTH-1]});

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    result = bus_a;
    case (alu_sel)
      OP_ADD:  result = bus_a + bus_b;
      OP_SUB:  result = bus_a - bus_b;
      OP_MUL:  result = bus_a * bus_b;
      OP_HALF: result = w_biased >>> 1;
      default: result = bus_a;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Accumulator controller: accepts one command, executes it for one cycle, then
// holds the result beat until consumed. Sticky err marks reserved opcodes.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W_ALU_SEL-1:0]    in_op,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_zero,
  output logic                    out_negative,
  output logic                    err
);

  state_e                  r_state;
  state_e                  w_next;
  logic [W_ALU_SEL-1:0]    r_op;
  logic signed [WIDTH-1:0] r_operand;
  logic signed [WIDTH-1:0] r_acc;
  logic                    r_zero;
  logic                    r_neg;
  logic                    r_err;
  logic signed [WIDTH-1:0] w_alu;
  logic signed [WIDTH-1:0] w_result;
  logic                    w_reserved;
  logic                    w_accept;

  alu #(.WIDTH(WIDTH)) u_alu (
    .bus_a   (r_acc),
    .bus_b   (r_operand),
    .alu_sel (r_op),
    .result  (w_alu)
  );

  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_next = S_EXEC;
      end
      S_EXEC: w_next = S_HOLD;
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_next = w_accept ? S_EXEC : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // LOAD, CLR and reserved opcodes bypass the ALU; reserved ones keep acc.
  always_comb begin
    w_result   = r_acc;
    w_reserved = 1'b0;
    case (r_op)
      OP_LOAD:                        w_result = r_operand;
      OP_CLR:                         w_result = '0;
      OP_ADD, OP_SUB, OP_MUL, OP_HALF: w_result = w_alu;
      default:                        w_reserved = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_operand <= '0;
      r_acc     <= '0;
      r_zero    <= 1'b1;
      r_neg     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op      <= in_op;
        r_operand <= in_data;
      end
      if (r_state == S_EXEC) begin
        r_acc  <= w_result;
        r_zero <= (w_result == '0);
        r_neg  <= w_result[WIDTH-1];
        if (w_reserved) r_err <= 1'b1;
      end
    end
  end

  assign out_data     = r_acc;
  assign out_zero     = r_zero;
  assign out_negative = r_neg;
  assign err          = r_err;

endmodule
